// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Also holds the per-nibble add-3 step used by the double-dabble converter.
package sevenseg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      HOLD
   } state_e;

   localparam logic [3:0]  DIGIT_DASH  = 4'hF;
   localparam int unsigned MAX_DISPLAY = 9999;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_A    = 2'b01;
   localparam logic [1:0] OWNER_B    = 2'b10;

   // Any nibble >= 5 must be corrected before the next shift doubles it.
   function automatic logic [15:0] bcd_add3(input logic [15:0] b);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift-and-add-3 per cycle, VAL_W cycles per value.
// done pulses for one cycle once bcd holds the final result.
module bin2bcd_seq
   import sevenseg_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [VAL_W-1:0] bin,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

   logic [VAL_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [15+VAL_W:0] shift;

   always_comb begin
      shift    = {bcd_add3(bcd_q), bin_q} << 1;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (start) begin
         bin_d    = bin;
         bcd_d    = '0;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         bcd_d = shift[15+VAL_W:VAL_W];
         bin_d = shift[VAL_W-1:0];
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(VAL_W - 1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/sevenseg_display_ctrl.sv
// Round-robin share of a 4-digit seven-segment display between two requesters.
// Granted value is converted to BCD, shown atomically, then held HOLD_CYCLES.
module sevenseg_display_ctrl
   import sevenseg_pkg::*;
#(
   parameter int VAL_W       = 14,
   parameter int HOLD_CYCLES = 100000000,
   parameter int HOLD_W      = 27
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_a,
   input  logic [VAL_W-1:0] val_a,
   input  logic             req_b,
   input  logic [VAL_W-1:0] val_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [3:0]       ones,
   output logic [3:0]       tens,
   output logic [3:0]       hundreds,
   output logic [3:0]       thousands,
   output logic [1:0]       owner,
   output logic             busy
);

   state_e            state_q, state_d;
   logic              rr_q, rr_d;       // 1: B wins the next tie
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        pend_q, pend_d;
   logic              oor_q, oor_d;
   logic              busy_q, busy_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0][3:0]   dig_q, dig_d;

   logic             grant_a, grant_b;
   logic [VAL_W-1:0] sel_val;
   logic             sel_oor;
   logic             conv_start;
   logic             conv_done;
   logic [15:0]      conv_bcd;

   bin2bcd_seq #(
      .VAL_W (VAL_W)
   ) u_bin2bcd (
      .clk   (clk),
      .clr   (clr),
      .start (conv_start),
      .bin   (sel_val),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      grant_a    = (state_q == IDLE) && req_a && (!req_b || !rr_q);
      grant_b    = (state_q == IDLE) && req_b && (!req_a ||  rr_q);
      sel_val    = grant_b ? val_b : val_a;
      sel_oor    = 32'(sel_val) > MAX_DISPLAY;
      // Out-of-range captures never start the converter.
      conv_start = (grant_a || grant_b) && !sel_oor;

      state_d = state_q;
      rr_d    = rr_q;
      ack_a_d = 1'b0;
      ack_b_d = 1'b0;
      owner_d = owner_q;
      pend_d  = pend_q;
      oor_d   = oor_q;
      hold_d  = hold_q;
      dig_d   = dig_q;

      case (state_q)
         IDLE: begin
            if (grant_a || grant_b) begin
               ack_a_d = grant_a;
               ack_b_d = grant_b;
               rr_d    = grant_a;
               pend_d  = grant_a ? OWNER_A : OWNER_B;
               oor_d   = sel_oor;
               state_d = CONV;
            end
         end
         CONV: begin
            if (oor_q) begin
               dig_d   = {4{DIGIT_DASH}};
               owner_d = pend_q;
               hold_d  = '0;
               state_d = HOLD;
            end else if (conv_done) begin
               dig_d   = conv_bcd;
               owner_d = pend_q;
               hold_d  = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         owner_q <= OWNER_NONE;
         pend_q  <= OWNER_NONE;
         oor_q   <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
         dig_q   <= {4{DIGIT_DASH}};
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         ack_a_q <= ack_a_d;
         ack_b_q <= ack_b_d;
         owner_q <= owner_d;
         pend_q  <= pend_d;
         oor_q   <= oor_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         dig_q   <= dig_d;
      end
   end

   assign ack_a     = ack_a_q;
   assign ack_b     = ack_b_q;
   assign ones      = dig_q[0];
   assign tens      = dig_q[1];
   assign hundreds  = dig_q[2];
   assign thousands = dig_q[3];
   assign owner     = owner_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
// Directed bench for sevenseg_display_ctrl with a short hold time.
module tb_sevenseg_display_ctrl;

   localparam int VAL_W       = 14;
   localparam int HOLD_CYCLES = 8;
   localparam int HOLD_W      = 4;

   logic             clk;
   logic             clr;
   logic             req_a, req_b;
   logic [VAL_W-1:0] val_a, val_b;
   logic             ack_a, ack_b;
   logic [3:0]       ones, tens, hundreds, thousands;
   logic [1:0]       owner;
   logic             busy;
   logic [15:0]      disp;

   int n_vec = 0;
   int n_err = 0;

   sevenseg_display_ctrl #(
      .VAL_W       (VAL_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_W      (HOLD_W)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .req_a     (req_a),
      .val_a     (val_a),
      .req_b     (req_b),
      .val_b     (val_b),
      .ack_a     (ack_a),
      .ack_b     (ack_b),
      .ones      (ones),
      .tens      (tens),
      .hundreds  (hundreds),
      .thousands (thousands),
      .owner     (owner),
      .busy      (busy)
   );

   assign disp = {thousands, hundreds, tens, ones};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   initial begin
      int   k;
      logic seen;

      // reset then idle
      clr = 1'b1; req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
      tick(); tick();
      clr = 1'b0;
      chk("rst_disp",  32'(disp),  32'hFFFF);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_ack",   32'({ack_a, ack_b}), 0);
      tick(); tick();
      chk("idle_disp", 32'(disp), 32'hFFFF);
      chk("idle_busy", 32'(busy), 0);

      // single conversion, request withdrawn after the ack
      req_a = 1'b1; val_a = 14'd1234;
      tick();
      chk("c1_ack_a",  32'(ack_a), 1);
      chk("c1_ack_b",  32'(ack_b), 0);
      chk("c1_busy",   32'(busy),  1);
      chk("c1_e0disp", 32'(disp),  32'hFFFF);
      tick();
      chk("c1_ackoff", 32'(ack_a), 0);
      req_a = 1'b0;
      repeat (13) tick();
      chk("c1_e14disp", 32'(disp), 32'hFFFF);
      tick();
      chk("c1_e15disp", 32'(disp),  32'h1234);
      chk("c1_owner",   32'(owner), 1);
      k = 15;
      while (busy && k < 100) begin
         tick();
         k++;
      end
      chk("c1_busylen", k, 23);
      repeat (4) tick();
      chk("c1_noack",   32'({ack_a, ack_b}), 0);
      chk("c1_persist", 32'(disp), 32'h1234);
      chk("c1_idle",    32'(busy), 0);

      // contention from reset
      clr = 1'b1; req_a = 1'b1; req_b = 1'b1; val_a = 14'd42; val_b = 14'd9999;
      tick();
      chk("c3_rst_disp", 32'(disp), 32'hFFFF);
      clr = 1'b0;
      tick();
      chk("c3_first", 32'({ack_a, ack_b}), 32'b10);
      seen = 1'b0;
      for (int i = 1; i <= 23; i++) begin
         tick();
         seen = seen | ack_a | ack_b;
         if (i == 15) begin
            chk("c3_a_disp",  32'(disp),  32'h0042);
            chk("c3_a_owner", 32'(owner), 1);
         end
      end
      chk("c3_noack_busy", 32'(seen), 0);
      chk("c3_idle",       32'(busy), 0);
      tick();
      chk("c3_second", 32'({ack_a, ack_b}), 32'b01);
      req_b = 1'b0;
      repeat (15) tick();
      chk("c3_b_disp",  32'(disp),  32'h9999);
      chk("c3_b_owner", 32'(owner), 2);
      repeat (9) tick();
      chk("c3_third", 32'({ack_a, ack_b}), 32'b10);
      req_a = 1'b0;
      wait_idle();
      chk("c3_a2_disp", 32'(disp), 32'h0042);

      // out-of-range capture
      req_b = 1'b1; val_b = 14'd10000;
      tick();
      chk("oor_ack",    32'({ack_a, ack_b}), 32'b01);
      chk("oor_e0disp", 32'(disp), 32'h0042);
      req_b = 1'b0;
      tick();
      chk("oor_disp",  32'(disp),  32'hFFFF);
      chk("oor_owner", 32'(owner), 2);
      chk("oor_busy",  32'(busy),  1);
      k = 1;
      while (busy && k < 100) begin
         tick();
         k++;
      end
      chk("oor_busylen", k, 9);

      // zero and a small value without blanking
      req_a = 1'b1; val_a = 14'd0;
      tick();
      req_a = 1'b0;
      repeat (15) tick();
      chk("zero_disp",  32'(disp),  32'h0000);
      chk("zero_owner", 32'(owner), 1);
      wait_idle();
      req_b = 1'b1; val_b = 14'd7;
      tick();
      req_b = 1'b0;
      repeat (15) tick();
      chk("seven_disp",  32'(disp),  32'h0007);
      chk("seven_owner", 32'(owner), 2);
      wait_idle();

      // clear during conversion, pending request re-granted
      req_a = 1'b1; val_a = 14'd5678;
      tick();
      chk("clr_ack0", 32'(ack_a), 1);
      repeat (6) tick();
      clr = 1'b1;
      tick();
      chk("clr_disp",  32'(disp),  32'hFFFF);
      chk("clr_owner", 32'(owner), 0);
      chk("clr_busy",  32'(busy),  0);
      chk("clr_ack",   32'({ack_a, ack_b}), 0);
      clr = 1'b0;
      tick();
      chk("clr_regrant", 32'({ack_a, ack_b}), 32'b10);
      req_a = 1'b0;
      repeat (15) tick();
      chk("clr_disp2",  32'(disp),  32'h5678);
      chk("clr_owner2", 32'(owner), 1);
      wait_idle();
      repeat (3) tick();
      chk("end_noack", 32'({ack_a, ack_b}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
